// File: rtl/qbert_pkg.sv
// Shared types and default constants for the Q*bert front-end control logic.
package qbert_pkg;

    typedef enum logic {SCR_IDLE, SCR_PLAY} screen_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 500_000;
    localparam int LOCKOUT_CYCLES_DEF  = 8_000_000;
    localparam int MAX_CREDITS_DEF     = 9;
    localparam int CREDIT_W_DEF        = 4;

    // Width of a down/up counter that must hold values 0..n-1 (at least one bit).
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability counter for one raw push-button.
// The level only changes after DEBOUNCE_CYCLES consecutive synced samples disagree with it;
// rise_o is a registered one-cycle pulse in the same cycle the level first reads high.
module btn_debounce
    import qbert_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = cntWidth(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] count_q, count_d;
    logic          rise_q, rise_d;

    // Count disagreeing samples; flip the level on the last one and flag a rising flip.
    always_comb begin
        level_d = level_q;
        count_d = count_q;
        rise_d  = 1'b0;
        if (sync2_q == level_q) begin
            count_d = '0;
        end else if (count_q == CNT_LAST) begin
            level_d = sync2_q;
            count_d = '0;
            rise_d  = sync2_q;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    // Synchronizer, debounce state and edge pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            count_q <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            count_q <= count_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/coin_credit_ctrl.sv
// Coin/start front end for the game-over screen: debounced buttons, arcade credit counter,
// post-coin lockout matching the coin animation, and the IDLE/PLAY screen state.
module coin_credit_ctrl
    import qbert_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF,
    parameter int MAX_CREDITS     = MAX_CREDITS_DEF,
    parameter int CREDIT_W        = CREDIT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_btn,
    input  logic                start_btn,
    input  logic                mode_arcade,
    input  logic                game_over,
    output logic                e_piece,
    output logic                coin_reject,
    output logic                game_start,
    output logic [CREDIT_W-1:0] credits,
    output logic                in_play
);

    localparam int LW = cntWidth(LOCKOUT_CYCLES);
    localparam logic [LW-1:0]       LOCK_LOAD  = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(MAX_CREDITS);

    logic coinLevel, coinRise;
    logic startLevel, startRise;
    logic coinEvent, startEvent;
    logic coinAccept, startAccept;

    screen_state_t       state_q, state_d;
    logic [CREDIT_W-1:0] credits_q, credits_d;
    logic [LW-1:0]       lockout_q, lockout_d;
    logic                ePiece_q, ePiece_d;
    logic                coinReject_q, coinReject_d;
    logic                gameStart_q, gameStart_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_coinDeb (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (coin_btn),
        .level_o (coinLevel),
        .rise_o  (coinRise)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_startDeb (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (start_btn),
        .level_o (startLevel),
        .rise_o  (startRise)
    );

    assign coinEvent  = coinRise & coinLevel;
    assign startEvent = startRise & startLevel;

    // Decide coin/start outcomes from pre-cycle credits, then derive credits, lockout and screen.
    always_comb begin
        coinAccept   = coinEvent && mode_arcade && (lockout_q == '0) && (credits_q < CREDIT_MAX);
        startAccept  = startEvent && (state_q == SCR_IDLE) && (!mode_arcade || (credits_q != '0));
        state_d      = state_q;
        credits_d    = credits_q;
        lockout_d    = lockout_q;
        ePiece_d     = coinAccept;
        coinReject_d = coinEvent && !coinAccept;
        gameStart_d  = startAccept;

        case ({coinAccept, startAccept && mode_arcade})
            2'b10:   credits_d = credits_q + CREDIT_W'(1);
            2'b01:   credits_d = credits_q - CREDIT_W'(1);
            default: credits_d = credits_q;
        endcase

        if (coinAccept) begin
            lockout_d = LOCK_LOAD;
        end else if (lockout_q != '0) begin
            lockout_d = lockout_q - LW'(1);
        end

        case (state_q)
            SCR_IDLE: if (startAccept) state_d = SCR_PLAY;
            SCR_PLAY: if (game_over)   state_d = SCR_IDLE;
            default:                   state_d = SCR_IDLE;
        endcase
    end

    // State, counters and registered output pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SCR_IDLE;
            credits_q    <= '0;
            lockout_q    <= '0;
            ePiece_q     <= 1'b0;
            coinReject_q <= 1'b0;
            gameStart_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            credits_q    <= credits_d;
            lockout_q    <= lockout_d;
            ePiece_q     <= ePiece_d;
            coinReject_q <= coinReject_d;
            gameStart_q  <= gameStart_d;
        end
    end

    assign e_piece     = ePiece_q;
    assign coin_reject = coinReject_q;
    assign game_start  = gameStart_q;
    assign credits     = credits_q;
    assign in_play     = (state_q == SCR_PLAY);

endmodule
